// File: rtl/rx_path_sequencer_pkg.sv
// Shared RX definitions: sequencer state encoding, GEN limits, lane count and lane-mask decode.
package rx_path_sequencer_pkg;

  localparam int unsigned NUM_LANES  = 16;
  localparam int unsigned LANE_CNT_W = 5;
  localparam int unsigned GEN_W      = 3;
  localparam int unsigned STATE_W    = 3;

  localparam logic [GEN_W-1:0] GEN_MIN = 3'd1;
  localparam logic [GEN_W-1:0] GEN_MAX = 3'd5;

  typedef enum logic [STATE_W-1:0] {
    IDLE       = 3'd0,
    WAIT_PHY   = 3'd1,
    WAIT_LOCK  = 3'd2,
    DESCR_INIT = 3'd3,
    READY      = 3'd4,
    ERROR      = 3'd5
  } seqState_t;

  // Lane count -> contiguous mask; 0 counts as one lane, anything above NUM_LANES saturates.
  function automatic logic [NUM_LANES-1:0] laneMaskDecode(input logic [LANE_CNT_W-1:0] lanes);
    logic [LANE_CNT_W-1:0] n;
    logic [NUM_LANES:0]    full;
    n = lanes;
    if (n == '0) begin
      n = LANE_CNT_W'(1);
    end else if (n > LANE_CNT_W'(NUM_LANES)) begin
      n = LANE_CNT_W'(NUM_LANES);
    end
    full = ((NUM_LANES+1)'(1) << n) - (NUM_LANES+1)'(1);
    return full[NUM_LANES-1:0];
  endfunction

endpackage

// File: rtl/rx_path_sequencer_if.sv
// Request/PIPE-status inputs and datapath-control outputs of the RX path sequencer.
interface rx_path_sequencer_if;
  import rx_path_sequencer_pkg::*;

  logic                  rateChangeReq;
  logic [GEN_W-1:0]      reqGEN;
  logic [LANE_CNT_W-1:0] numberOfDetectedLanes;
  logic [NUM_LANES-1:0]  PhyStatus;
  logic [NUM_LANES-1:0]  RxValid;
  logic [NUM_LANES-1:0]  RxElectricalIdle;

  logic [GEN_W-1:0]      GEN;
  logic [NUM_LANES-1:0]  laneMask;
  logic                  datapathFlush;
  logic                  descramblerReset;
  logic                  rxPathReady;
  logic                  rateChangeAck;
  logic                  timeoutError;
  logic                  rateError;
  logic [STATE_W-1:0]    seqState;

  modport master (
    output rateChangeReq, reqGEN, numberOfDetectedLanes, PhyStatus, RxValid, RxElectricalIdle,
    input  GEN, laneMask, datapathFlush, descramblerReset, rxPathReady, rateChangeAck,
           timeoutError, rateError, seqState
  );

  modport slave (
    input  rateChangeReq, reqGEN, numberOfDetectedLanes, PhyStatus, RxValid, RxElectricalIdle,
    output GEN, laneMask, datapathFlush, descramblerReset, rxPathReady, rateChangeAck,
           timeoutError, rateError, seqState
  );

endinterface

// File: rtl/rx_path_sequencer.sv
// RX path bring-up sequencer: rate change, PHY status wait, lane lock, descrambler reseed, ready.
module rx_path_sequencer
  import rx_path_sequencer_pkg::*;
#(
  parameter int unsigned LOCK_CYCLES    = 8,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input logic                clk,
  input logic                reset,
  rx_path_sequencer_if.slave rx
);

  localparam int unsigned LOCK_W = 8;
  localparam int unsigned TO_W   = 16;

  seqState_t            state, stateNext;
  logic [GEN_W-1:0]     gen, genNext;
  logic [NUM_LANES-1:0] laneMask, laneMaskNext;
  logic [NUM_LANES-1:0] sticky, stickyNext;
  logic [LOCK_W-1:0]    lockCnt, lockCntNext, lockInc;
  logic [TO_W-1:0]      toCnt, toCntNext, toInc;
  logic                 ackNext, reqOk, reqBad, lanesGood, phyDone, timedOut, lockDone;
  logic                 datapathFlush, descramblerReset, rxPathReady;
  logic                 rateChangeAck, timeoutError, rateError;

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= stateNext;
  end

  // Next-state and counter/mask updates; an accepted request overrides every other event
  always_comb begin
    reqOk     = rx.rateChangeReq && (rx.reqGEN >= GEN_MIN) && (rx.reqGEN <= GEN_MAX);
    reqBad    = rx.rateChangeReq && !reqOk;
    lanesGood = ((rx.RxValid & ~rx.RxElectricalIdle) & laneMask) == laneMask;
    phyDone   = ((sticky | rx.PhyStatus) & laneMask) == laneMask;
    lockInc   = lockCnt + LOCK_W'(1);
    toInc     = toCnt + TO_W'(1);
    timedOut  = (toInc == TO_W'(TIMEOUT_CYCLES));
    lockDone  = (lockInc == LOCK_W'(LOCK_CYCLES));

    stateNext    = state;
    genNext      = gen;
    laneMaskNext = laneMask;
    stickyNext   = sticky;
    lockCntNext  = lockCnt;
    toCntNext    = toCnt;
    ackNext      = 1'b0;

    if (reqOk) begin
      stateNext    = WAIT_PHY;
      genNext      = rx.reqGEN;
      laneMaskNext = laneMaskDecode(rx.numberOfDetectedLanes);
      stickyNext   = '0;
      lockCntNext  = '0;
      toCntNext    = '0;
    end else begin
      case (state)
        WAIT_PHY: begin
          stickyNext = sticky | (rx.PhyStatus & laneMask);
          toCntNext  = toInc;
          if (timedOut)     stateNext = ERROR;
          else if (phyDone) stateNext = WAIT_LOCK;
        end
        WAIT_LOCK: begin
          toCntNext   = toInc;
          lockCntNext = lanesGood ? lockInc : '0;
          if (timedOut)                  stateNext = ERROR;
          else if (lanesGood && lockDone) stateNext = DESCR_INIT;
        end
        DESCR_INIT: begin
          stateNext = READY;
          ackNext   = 1'b1;
        end
        READY: begin
          // Lane loss re-locks at the current rate; the timeout budget starts afresh
          if (!lanesGood) begin
            stateNext   = WAIT_LOCK;
            lockCntNext = '0;
            toCntNext   = '0;
          end
        end
        default: ;
      endcase
    end
  end

  // Datapath registers and registered outputs, all decoded from the next state
  always_ff @(posedge clk) begin
    if (reset) begin
      gen              <= GEN_MIN;
      laneMask         <= NUM_LANES'(1);
      sticky           <= '0;
      lockCnt          <= '0;
      toCnt            <= '0;
      datapathFlush    <= 1'b1;
      descramblerReset <= 1'b1;
      rxPathReady      <= 1'b0;
      rateChangeAck    <= 1'b0;
      timeoutError     <= 1'b0;
      rateError        <= 1'b0;
    end else begin
      gen              <= genNext;
      laneMask         <= laneMaskNext;
      sticky           <= stickyNext;
      lockCnt          <= lockCntNext;
      toCnt            <= toCntNext;
      datapathFlush    <= (stateNext != READY);
      descramblerReset <= (stateNext == DESCR_INIT);
      rxPathReady      <= (stateNext == READY);
      rateChangeAck    <= ackNext;
      timeoutError     <= (stateNext == ERROR);
      rateError        <= reqBad;
    end
  end

  assign rx.GEN              = gen;
  assign rx.laneMask         = laneMask;
  assign rx.datapathFlush    = datapathFlush;
  assign rx.descramblerReset = descramblerReset;
  assign rx.rxPathReady      = rxPathReady;
  assign rx.rateChangeAck    = rateChangeAck;
  assign rx.timeoutError     = timeoutError;
  assign rx.rateError        = rateError;
  assign rx.seqState         = state;

endmodule

// File: tb/tb_rx_path_sequencer.sv
// Scoreboard bench: transactions predict ack/timeout/rate-error events; a monitor pops and compares.
module tb_rx_path_sequencer;

  localparam int LOCK = 8;
  localparam int TMO  = 16;
  localparam int RLEN = 24;
  localparam int EV_ACK = 0, EV_TMO = 1, EV_RATE = 2;
  localparam int S_IDLE = 0, S_PHY = 1, S_LOCK = 2, S_DESCR = 3, S_READY = 4, S_ERR = 5;

  typedef struct { int kind; int cyc; int gen; int mask; int st; } evt_t;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  int   cyc     = 0;
  int   nChecks = 0;
  int   nPass   = 0;
  evt_t expQ[$];
  int   arrival[16];
  bit   badAt[RLEN];
  int   badLane  = -1;
  int   curGen   = 1;
  int   curMask  = 1;
  int   curState = 0;
  bit   prevTo   = 1'b0;

  rx_path_sequencer_if rx();

  rx_path_sequencer #(.LOCK_CYCLES(LOCK), .TIMEOUT_CYCLES(TMO)) dut (
    .clk  (clk),
    .reset(reset),
    .rx   (rx)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1);
  end

  task automatic chk(input string name, input int act, input int exp);
    nChecks++;
    if (act == exp) nPass++;
    else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  function automatic int modelMask(input int n);
    int lanes;
    int m;
    lanes = (n == 0) ? 1 : ((n > 16) ? 16 : n);
    m = 0;
    for (int i = 0; i < lanes; i++) m = m | (1 << i);
    return m;
  endfunction

  task automatic pushExp(input int kind, input int c, input int g, input int m, input int s);
    evt_t e;
    e.kind = kind; e.cyc = c; e.gen = g; e.mask = m; e.st = s;
    expQ.push_back(e);
  endtask

  task automatic compareEvt(input int kind);
    evt_t e;
    if (expQ.size() == 0) begin
      chk("unexpected event kind", kind, -1);
      return;
    end
    e = expQ.pop_front();
    chk("event kind", kind, e.kind);
    chk("event cycle", cyc, e.cyc);
    chk("event GEN", int'(rx.GEN), e.gen);
    chk("event laneMask", int'(rx.laneMask), e.mask);
    chk("event seqState", int'(rx.seqState), e.st);
  endtask

  // Monitor: compares every observable completion event against the scoreboard
  initial begin
    forever begin
      @(negedge clk);
      if (reset) begin
        prevTo = 1'b0;
      end else begin
        if (rx.rateChangeAck) compareEvt(EV_ACK);
        if (rx.rateError) compareEvt(EV_RATE);
        if (rx.timeoutError && !prevTo) compareEvt(EV_TMO);
        prevTo = rx.timeoutError;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idleDrive();
    rx.rateChangeReq         = 1'b0;
    rx.PhyStatus             = '0;
    rx.RxValid               = '1;
    rx.RxElectricalIdle      = 16'($urandom) & ~16'(curMask);
  endtask

  // Inputs for relative cycle r of a sequence; inactive lanes carry random junk
  task automatic driveRel(input int r, input int m);
    logic [15:0] ps, rv, ei, m16;
    int l;
    m16 = 16'(m);
    ps  = 16'($urandom) & ~m16;
    for (int i = 0; i < 16; i++) if (m16[i] && arrival[i] == r) ps[i] = 1'b1;
    rv = m16 | 16'($urandom);
    ei = 16'($urandom) & ~m16;
    if (badAt[r]) begin
      l = (badLane >= 0) ? badLane : $urandom_range(0, $countones(m16) - 1);
      if ($urandom_range(0, 1) == 1) rv[l] = 1'b0;
      else                           ei[l] = 1'b1;
    end
    rx.rateChangeReq    = 1'b0;
    rx.PhyStatus        = ps;
    rx.RxValid          = rv;
    rx.RxElectricalIdle = ei;
  endtask

  task automatic checkResetOutputs();
    chk("reset seqState", int'(rx.seqState), S_IDLE);
    chk("reset GEN", int'(rx.GEN), 1);
    chk("reset laneMask", int'(rx.laneMask), 1);
    chk("reset datapathFlush", int'(rx.datapathFlush), 1);
    chk("reset descramblerReset", int'(rx.descramblerReset), 1);
    chk("reset rxPathReady", int'(rx.rxPathReady), 0);
    chk("reset rateChangeAck", int'(rx.rateChangeAck), 0);
    chk("reset timeoutError", int'(rx.timeoutError), 0);
    chk("reset rateError", int'(rx.rateError), 0);
  endtask

  task automatic rawReq(input int g, input int n);
    rx.rateChangeReq         = 1'b1;
    rx.reqGEN                = 3'(g);
    rx.numberOfDetectedLanes = 5'(n);
    step();
    rx.rateChangeReq         = 1'b0;
  endtask

  // One full sequence: predict outcome from arrival/badAt, push it, then drive RLEN cycles
  task automatic runTxn(input int g, input int n);
    int m, d, j, run, k;
    bit never, ok;
    m = modelMask(n);
    d = 0;
    never = 1'b0;
    for (int i = 0; i < 16; i++) begin
      if (m[i]) begin
        if (arrival[i] >= RLEN) never = 1'b1;
        else if (arrival[i] > d) d = arrival[i];
      end
    end
    j = -1;
    run = 0;
    if (!never) begin
      for (int r = d + 1; r < RLEN && j < 0; r++) begin
        run = badAt[r] ? 0 : run + 1;
        if (run == LOCK) j = r;
      end
    end
    ok = (j >= 0) && (j < TMO - 1);
    if (ok) for (int r = j + 1; r < RLEN; r++) badAt[r] = 1'b0;
    k = cyc;
    if (ok) pushExp(EV_ACK, k + j + 3, g, m, S_READY);
    else    pushExp(EV_TMO, k + 1 + TMO, g, m, S_ERR);
    curGen = g;
    curMask = m;
    curState = ok ? S_READY : S_ERR;
    rawReq(g, n);
    for (int r = 0; r < RLEN; r++) begin
      driveRel(r, m);
      if (ok) begin
        if (r <= d) chk("WAIT_PHY hold", int'(rx.seqState), S_PHY);
        if (r == d + 1) chk("WAIT_LOCK entry", int'(rx.seqState), S_LOCK);
        if (r == j + 1) begin
          chk("DESCR_INIT state", int'(rx.seqState), S_DESCR);
          chk("descramblerReset pulse", int'(rx.descramblerReset), 1);
        end
        if (r == j + 2) begin
          chk("READY rxPathReady", int'(rx.rxPathReady), 1);
          chk("READY datapathFlush", int'(rx.datapathFlush), 0);
        end
        if (r == j + 3) begin
          chk("descramblerReset low", int'(rx.descramblerReset), 0);
          chk("ack single pulse", int'(rx.rateChangeAck), 0);
        end
      end else if (r == TMO) begin
        chk("ERROR state", int'(rx.seqState), S_ERR);
        chk("ERROR datapathFlush", int'(rx.datapathFlush), 1);
      end
      step();
    end
    idleDrive();
  endtask

  task automatic readyLoss(input int lane);
    int k;
    k = cyc;
    pushExp(EV_ACK, k + LOCK + 2, curGen, curMask, S_READY);
    idleDrive();
    rx.RxElectricalIdle[lane] = 1'b1;
    step();
    idleDrive();
    chk("lane loss seqState", int'(rx.seqState), S_LOCK);
    chk("lane loss datapathFlush", int'(rx.datapathFlush), 1);
    chk("lane loss rxPathReady", int'(rx.rxPathReady), 0);
    chk("lane loss GEN", int'(rx.GEN), curGen);
    repeat (LOCK + 4) step();
  endtask

  task automatic badReq(input int g);
    int k;
    k = cyc;
    pushExp(EV_RATE, k + 1, curGen, curMask, curState);
    rx.rateChangeReq = 1'b1;
    rx.reqGEN        = 3'(g);
    step();
    rx.rateChangeReq = 1'b0;
    chk("bad request seqState", int'(rx.seqState), curState);
    chk("bad request GEN", int'(rx.GEN), curGen);
    step();
  endtask

  task automatic clearPattern();
    for (int i = 0; i < 16; i++) arrival[i] = 0;
    for (int r = 0; r < RLEN; r++) badAt[r] = 1'b0;
    badLane = -1;
  endtask

  initial begin
    rx.reqGEN = 3'd1;
    rx.numberOfDetectedLanes = 5'd1;
    idleDrive();
    reset = 1'b1;
    repeat (3) step();
    checkResetOutputs();
    reset = 1'b0;
    step();
    chk("IDLE descramblerReset drop", int'(rx.descramblerReset), 0);
    chk("IDLE datapathFlush", int'(rx.datapathFlush), 1);
    chk("IDLE seqState", int'(rx.seqState), S_IDLE);

    // Basic bring-up at GEN3, four lanes
    clearPattern();
    runTxn(3, 4);

    // Staggered PhyStatus merged through the sticky mask
    clearPattern();
    arrival[0] = 1;
    for (int i = 1; i < 4; i++) arrival[i] = 4;
    runTxn(4, 4);

    // Lane 2 glitch after five good cycles restarts the lock count
    clearPattern();
    badAt[6] = 1'b1;
    badLane  = 2;
    runTxn(2, 4);
    badLane  = -1;

    // Lane loss in READY, then an illegal rate request
    readyLoss(0);
    badReq(7);

    // Request aborting a sequence already in WAIT_LOCK
    clearPattern();
    rawReq(2, 8);
    for (int r = 0; r < 3; r++) begin
      driveRel(r, modelMask(8));
      step();
    end
    runTxn(5, 6);

    // PhyStatus never completes -> timeout, illegal request in ERROR, then recovery
    clearPattern();
    arrival[3] = 99;
    runTxn(5, 4);
    badReq(0);
    clearPattern();
    runTxn(1, 4);

    // Reset asserted mid-WAIT_LOCK
    clearPattern();
    rawReq(4, 16);
    for (int r = 0; r < 2; r++) begin
      driveRel(r, modelMask(16));
      step();
    end
    reset = 1'b1;
    step();
    checkResetOutputs();
    curGen = 1; curMask = 1; curState = S_IDLE;
    reset = 1'b0;
    idleDrive();
    step();

    // Randomised sequences
    for (int t = 0; t < 30; t++) begin
      for (int i = 0; i < 16; i++) arrival[i] = $urandom_range(0, 5);
      if ($urandom_range(0, 7) == 0) arrival[$urandom_range(0, 15)] = 99;
      for (int r = 0; r < RLEN; r++) badAt[r] = ($urandom_range(0, 9) == 0);
      runTxn($urandom_range(1, 5), $urandom_range(0, 20));
      if (curState == S_READY && $urandom_range(0, 1) == 1)
        readyLoss($urandom_range(0, $countones(16'(curMask)) - 1));
      if ($urandom_range(0, 2) == 0) begin
        case ($urandom_range(0, 2))
          0:       badReq(0);
          1:       badReq(6);
          default: badReq(7);
        endcase
      end
    end

    repeat (5) step();
    chk("leftover expected events", expQ.size(), 0);
    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule

// File: doc/rx_path_sequencer.md
RX_PATH_SEQUENCER -- requirements
Module: rx_path_sequencer

Interface
REQ-001 The block SHALL have parameter LOCK_CYCLES, default 8: number of consecutive all-lanes-good cycles needed to declare lock (range 1..255).
REQ-002 The block SHALL have parameter TIMEOUT_CYCLES, default 1024: maximum cycles spent in WAIT_PHY plus WAIT_LOCK before an error is declared (range 16..65535).
REQ-003 The block SHALL have port clk, input, 1: the single clock; all logic is rising-edge.
REQ-004 The block SHALL have port reset, input, 1: reset, synchronous and active-high.
REQ-005 The block SHALL have port rateChangeReq, input, 1: single-cycle request to (re)start the sequence at reqGEN.
REQ-006 The block SHALL have port reqGEN, input, 3: requested generation, 1..5.
REQ-007 The block SHALL have port numberOfDetectedLanes, input, 5: number of active lanes.
REQ-008 The block SHALL have ports PhyStatus, RxValid and RxElectricalIdle, each input, 16: per-lane PIPE status, with lane i on bit i.
REQ-009 The block SHALL have port GEN, output, 3: generation applied to the PIPE/descrambler/LMC datapath.
REQ-010 The block SHALL have port laneMask, output, 16: active-lane mask.
REQ-011 The block SHALL have port datapathFlush, output, 1: holds the LMC/decoder/packet path in flush.
REQ-012 The block SHALL have port descramblerReset, output, 1: reseeds the per-lane descramblers.
REQ-013 The block SHALL have port rxPathReady, output, 1: the datapath is aligned and carrying valid data.
REQ-014 The block SHALL have port rateChangeAck, output, 1: single-cycle completion pulse.
REQ-015 The block SHALL have ports timeoutError and rateError, output, 1 each.
REQ-016 The block SHALL have port seqState, output, 3: current state encoding.

Function
REQ-017 States SHALL be IDLE=0, WAIT_PHY=1, WAIT_LOCK=2, DESCR_INIT=3, READY=4, ERROR=5.
REQ-018 laneMask SHALL equal (1<<n)-1, where n = numberOfDetectedLanes, with 0 treated as 1 and values >16 clamped to 16; it SHALL be registered and updated only when a request is accepted.
REQ-019 A request (rateChangeReq=1 with reqGEN in 1..5) accepted in any state SHALL, at the next edge, load GEN=reqGEN, enter WAIT_PHY, clear the PhyStatus sticky mask, clear the lock and timeout counters, set datapathFlush=1 and clear rxPathReady; acceptance in WAIT_PHY, WAIT_LOCK or DESCR_INIT SHALL abort and restart the sequence.
REQ-020 A request with reqGEN equal to 0 or 6..7 SHALL be ignored except for setting rateError=1 for one cycle; state and GEN SHALL be unchanged.
REQ-021 In WAIT_PHY, sticky |= PhyStatus & laneMask each cycle; when (sticky | PhyStatus) covers laneMask, the state SHALL move to WAIT_LOCK at the next edge.
REQ-022 In WAIT_LOCK, a cycle SHALL be "good" when every active lane has RxValid=1 and RxElectricalIdle=0; good cycles increment the lock counter and a bad cycle clears it to 0.
REQ-023 On the LOCK_CYCLES-th consecutive good cycle the state SHALL move to DESCR_INIT.
REQ-024 DESCR_INIT SHALL last exactly one cycle with descramblerReset=1; the state then moves to READY.
REQ-025 On entering READY: datapathFlush=0, rxPathReady=1, and rateChangeAck=1 for exactly the first READY cycle.
REQ-026 In READY, any active lane with RxValid=0 or RxElectricalIdle=1 SHALL cause a move to WAIT_LOCK at the next edge, with datapathFlush=1, rxPathReady=0 and the lock counter cleared; GEN is unchanged and no PHY wait occurs.
REQ-027 The timeout counter SHALL run in WAIT_PHY and WAIT_LOCK and SHALL NOT be reset by the WAIT_PHY->WAIT_LOCK transition; reaching TIMEOUT_CYCLES SHALL move the state to ERROR.
REQ-028 ERROR SHALL hold timeoutError=1 and datapathFlush=1, and SHALL leave only on an accepted request.
REQ-029 Simultaneous events: an accepted request SHALL take priority over timeout, lock completion and READY lane loss.
REQ-030 Inactive lanes (mask bit 0) SHALL be ignored in every check.

Reset
REQ-031 Asserting reset on any edge, including mid-sequence, SHALL give: state IDLE, GEN=1, laneMask=16'h0001, datapathFlush=1, descramblerReset=1, rxPathReady=0, rateChangeAck=0, timeoutError=0, rateError=0, and all counters and the sticky mask at 0.
REQ-032 In IDLE, descramblerReset SHALL drop to 0 one cycle after reset release, and datapathFlush SHALL remain 1.

Structure
REQ-033 The state encoding, the GEN range limits and the 16-lane constant SHALL live in the shared RX package.
REQ-034 The design SHALL be a single module with no sub-module; the lane-mask decode SHALL be a package function.

Verification
REQ-035 Scenario: reset, then request reqGEN=3 with 4 lanes; PhyStatus=16'h000F for 1 cycle; RxValid=F, EI=0 -> WAIT_PHY at T+1, WAIT_LOCK next, descramblerReset pulse after 8 good cycles, READY with GEN=3, laneMask=000F and a single ack pulse.
REQ-036 Scenario: PhyStatus arrives staggered (lane0 at T+2, lanes1-3 at T+5) -> sticky merge; WAIT_LOCK entered only after T+5.
REQ-037 Scenario: RxValid lane 2 drops for 1 cycle after 5 good cycles -> counter restarts; READY reached 8 cycles after recovery.
REQ-038 Scenario: PhyStatus never arrives (TIMEOUT_CYCLES=16) -> ERROR with timeoutError=1 at cycle 16; request reqGEN=1 -> recovers.
REQ-039 Scenario: in READY lane 0 shows EI=1 -> WAIT_LOCK with flush=1 and GEN unchanged; a reqGEN=7 request -> rateError pulse with state unchanged.
REQ-040 Scenario: reset asserted in WAIT_LOCK -> all outputs take their REQ-031 values at the next edge.
